// File: rtl/vector_fetch_unit.sv
// -----------------------------------------------------------------------------
// vector_fetch_unit
//   Fetches one VEC_LEN-element vector from a synchronous block RAM. A request
//   carries a vector index; the unit issues VEC_LEN reads (one per cycle),
//   tracks each read with a {valid, k} tag through a RD_LAT-deep pipeline, and
//   drops each returned word into element slot k. The full vector is then
//   presented with valid/ready.
//
//   Optional feature macro: FETCH_STRIDE_EN
//     defined   : idx < VEC_LEN selects row idx (contiguous addresses);
//                 idx >= VEC_LEN selects column idx-VEC_LEN (stride VEC_LEN).
//     undefined : every index is a contiguous row; no column logic exists.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous reset, active low
//   req_valid_i  fetch request present
//   req_ready_o  unit idle and able to accept a request (registered)
//   req_idx_i    vector index, sampled on request handshake
//   mem_en_o     RAM read enable
//   mem_addr_o   RAM read address
//   mem_data_i   RAM read data, RD_LAT cycles after mem_en_o
//   vec_valid_o  vec_data_o holds a complete vector
//   vec_ready_i  consumer accepts vec_data_o
//   vec_data_o   element k at [k*ELEM_W +: ELEM_W]
// -----------------------------------------------------------------------------
module vector_fetch_unit #(
   parameter int VEC_LEN   = 16,
   parameter int ELEM_W    = 32,
   parameter int ADDR_W    = 12,
   parameter int RD_LAT    = 1,
   parameter int BASE_ADDR = 0,
   parameter int IDX_W     = $clog2(2*VEC_LEN)
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic [IDX_W-1:0]          req_idx_i,
   output logic                      mem_en_o,
   output logic [ADDR_W-1:0]         mem_addr_o,
   input  logic [ELEM_W-1:0]         mem_data_i,
   output logic                      vec_valid_o,
   input  logic                      vec_ready_i,
   output logic [VEC_LEN*ELEM_W-1:0] vec_data_o
);

   localparam int K_W = $clog2(VEC_LEN);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   localparam logic [K_W-1:0]    K_LAST = K_W'(VEC_LEN-1);
   localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);

   logic [1:0]                     state_q, state_d;
   logic                           req_ready_q;
   logic                           mem_en_q, mem_en_d;
   logic [ADDR_W-1:0]              addr_q, addr_d;
   logic [K_W-1:0]                 k_q, k_d;
   logic                           vec_valid_q, vec_valid_d;
   logic [VEC_LEN-1:0][ELEM_W-1:0] vec_q;

   // Return-tag pipeline: stage i holds the tag of the read issued i cycles ago,
   // so stage RD_LAT lines up with the data coming back from the RAM.
   logic [RD_LAT:1]           vld_pipe_q;
   logic [RD_LAT:1][K_W-1:0]  k_pipe_q;
   logic                      ret_vld;
   logic [K_W-1:0]            ret_k;

   assign ret_vld = vld_pipe_q[RD_LAT];
   assign ret_k   = k_pipe_q[RD_LAT];

   // Row start: idx*VEC_LEN is a shift since VEC_LEN is a power of two.
   logic [ADDR_W-1:0] row_start;
   logic [ADDR_W-1:0] addr_step;
   assign row_start = BASE + (ADDR_W'(req_idx_i) << K_W);

`ifdef FETCH_STRIDE_EN
   logic              col_q, col_d;
   logic [ADDR_W-1:0] col_start;
   assign col_start = BASE + ADDR_W'(req_idx_i[K_W-1:0]);
   assign addr_step = col_q ? ADDR_W'(VEC_LEN) : ADDR_W'(1);
`else
   assign addr_step = ADDR_W'(1);
`endif

   always_comb begin
      state_d     = state_q;
      mem_en_d    = mem_en_q;
      addr_d      = addr_q;
      k_d         = k_q;
      vec_valid_d = vec_valid_q;
`ifdef FETCH_STRIDE_EN
      col_d       = col_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid_i && req_ready_q) begin
               state_d  = S_ISSUE;
               mem_en_d = 1'b1;
               k_d      = '0;
`ifdef FETCH_STRIDE_EN
               col_d    = (req_idx_i >= IDX_W'(VEC_LEN));
               addr_d   = col_d ? col_start : row_start;
`else
               addr_d   = row_start;
`endif
            end
         end
         S_ISSUE: begin
            if (k_q == K_LAST) begin
               state_d  = S_DRAIN;
               mem_en_d = 1'b0;
            end else begin
               k_d    = k_q + K_W'(1);
               addr_d = addr_q + addr_step;
            end
         end
         S_DRAIN: begin
            // Returns arrive in issue order, so the last slot written ends the fetch.
            if (ret_vld && ret_k == K_LAST) begin
               state_d     = S_HOLD;
               vec_valid_d = 1'b1;
            end
         end
         S_HOLD: begin
            if (vec_ready_i) begin
               state_d     = S_IDLE;
               vec_valid_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         req_ready_q <= 1'b1;
         mem_en_q    <= 1'b0;
         addr_q      <= '0;
         k_q         <= '0;
         vec_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= (state_d == S_IDLE);
         mem_en_q    <= mem_en_d;
         addr_q      <= addr_d;
         k_q         <= k_d;
         vec_valid_q <= vec_valid_d;
      end
   end

`ifdef FETCH_STRIDE_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) col_q <= 1'b0;
      else         col_q <= col_d;
   end
`endif

   // Clearing the tags on reset is what makes late RAM data harmless.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_pipe_q <= '0;
         k_pipe_q   <= '0;
      end else begin
         vld_pipe_q[1] <= mem_en_q;
         k_pipe_q[1]   <= k_q;
         for (int i = 2; i <= RD_LAT; i++) begin
            vld_pipe_q[i] <= vld_pipe_q[i-1];
            k_pipe_q[i]   <= k_pipe_q[i-1];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)      vec_q        <= '0;
      else if (ret_vld) vec_q[ret_k] <= mem_data_i;
   end

   assign req_ready_o = req_ready_q;
   assign mem_en_o    = mem_en_q;
   assign mem_addr_o  = addr_q;
   assign vec_valid_o = vec_valid_q;
   assign vec_data_o  = vec_q;

endmodule

// File: tb/tb_vector_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_vector_fetch_unit
//   Scoreboard bench for vector_fetch_unit. Each accepted request pushes its
//   expected address stream, result latency and result vector; a monitor pops
//   and compares whenever the DUT drives mem_en or completes a vector.
// -----------------------------------------------------------------------------
module tb_vector_fetch_unit;
   localparam int VL   = 16;
   localparam int EW   = 32;
   localparam int AW   = 12;
   localparam int RL   = 3;
   localparam int BASE = 0;
   localparam int IW   = $clog2(2*VL);
   localparam int VW   = VL*EW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [IW-1:0] req_idx = '0;
   logic          mem_en;
   logic [AW-1:0] mem_addr;
   logic [EW-1:0] mem_data;
   logic          vec_valid;
   logic          vec_ready = 1'b1;
   logic [VW-1:0] vec_data;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   vector_fetch_unit #(
      .VEC_LEN(VL), .ELEM_W(EW), .ADDR_W(AW), .RD_LAT(RL), .BASE_ADDR(BASE)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_idx_i(req_idx),
      .mem_en_o(mem_en), .mem_addr_o(mem_addr), .mem_data_i(mem_data),
      .vec_valid_o(vec_valid), .vec_ready_i(vec_ready), .vec_data_o(vec_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: word = FFFF_0000 | addr, RL cycles after the enable; garbage otherwise.
   logic [EW-1:0] rd_pipe [1:RL];
   always @(posedge clk) begin
      rd_pipe[1] <= mem_en ? (32'hFFFF_0000 | EW'(mem_addr)) : $urandom;
      for (int i = 2; i <= RL; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_data = rd_pipe[RL];

   // ---------------- reference model ----------------
   function automatic logic [AW-1:0] ref_addr(input int idx, input int k);
      int a;
`ifdef FETCH_STRIDE_EN
      if (idx < VL) a = BASE + idx*VL + k;
      else          a = BASE + k*VL + (idx - VL);
`else
      a = BASE + idx*VL + k;
`endif
      return AW'(a % (1 << AW));
   endfunction

   typedef struct { int cyc; logic [AW-1:0] addr; } aexp_t;
   aexp_t         aq[$];
   logic [VW-1:0] vq[$];
   int            rq[$];

   function automatic void chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic void fail_msg(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
   endfunction

   // hs = handshake cycle: addresses in hs+1..hs+VL, vec_valid in hs+VL+RL+1.
   function automatic void push_exp(input int idx, input int hs);
      logic [VW-1:0] v;
      aexp_t         e;
      v = '0;
      for (int k = 0; k < VL; k++) begin
         e.cyc  = hs + 1 + k;
         e.addr = ref_addr(idx, k);
         aq.push_back(e);
         v[k*EW +: EW] = 32'hFFFF_0000 | EW'(ref_addr(idx, k));
      end
      vq.push_back(v);
      rq.push_back(hs + VL + RL + 1);
   endfunction

   // ---------------- monitor ----------------
   logic          vv_prev = 1'b0;
   logic          after_vhs = 1'b0;
   logic [VW-1:0] held = '0;
   logic [VW-1:0] last_acc = '0;
   int            last_vhs = -10;
   aexp_t         mon_e;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            vv_prev   = 1'b0;
            after_vhs = 1'b0;
         end else begin
            if (after_vhs) begin
               chk("req_ready_after_vhs", VW'(req_ready), VW'(1));
               chk("vec_valid_after_vhs", VW'(vec_valid), VW'(0));
               chk("vec_data_kept", vec_data, last_acc);
               after_vhs = 1'b0;
            end
            if (mem_en) begin
               if (aq.size() == 0) fail_msg("spurious_mem_en");
               else begin
                  mon_e = aq.pop_front();
                  chk("mem_addr", VW'(mem_addr), VW'(mon_e.addr));
                  chk("addr_cycle", VW'(cyc), VW'(mon_e.cyc));
               end
            end
            if (vec_valid) begin
               if (!vv_prev) begin
                  if (rq.size() == 0) fail_msg("spurious_vec_valid");
                  else chk("vec_latency", VW'(cyc), VW'(rq.pop_front()));
                  held = vec_data;
               end else begin
                  chk("hold_stable", vec_data, held);
               end
               chk("req_ready_low_in_hold", VW'(req_ready), VW'(0));
               if (vec_ready) begin
                  if (vq.size() == 0) fail_msg("unexpected_vec");
                  else chk("vec_data", vec_data, vq.pop_front());
                  last_acc  = vec_data;
                  last_vhs  = cyc;
                  after_vhs = 1'b1;
               end
            end
            vv_prev = vec_valid && !vec_ready;
         end
      end
   end

   // ---------------- consumer ----------------
   int   vr_mode  = 0;     // 0: always ready, 1: random, 2: vr_force
   logic vr_force = 1'b1;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (vr_mode)
            0:       vec_ready = 1'b1;
            1:       vec_ready = ($urandom_range(0, 3) != 0);
            default: vec_ready = vr_force;
         endcase
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_req(input int idx, input bit keep, output int hs);
      int t;
      t = 0;
      hs = -1;
      req_valid = 1'b1;
      req_idx   = IW'(idx);
      while (!req_ready && t < 300) begin
         step();
         t++;
      end
      if (!req_ready) begin
         fail_msg("req_accept");
         req_valid = 1'b0;
         return;
      end
      hs = cyc;
      push_exp(idx, hs);
      step();
      if (!keep) req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (t < 600 && !(req_ready && !vec_valid && aq.size() == 0 && vq.size() == 0)) begin
         step();
         t++;
      end
      if (t >= 600) fail_msg("wait_idle");
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req_ready"}, VW'(req_ready), VW'(1));
      chk({tag, "_mem_en"},    VW'(mem_en),    VW'(0));
      chk({tag, "_mem_addr"},  VW'(mem_addr),  VW'(0));
      chk({tag, "_vec_valid"}, VW'(vec_valid), VW'(0));
      chk({tag, "_vec_data"},  vec_data,       VW'(0));
   endtask

   initial begin
      int hs;
      int t;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk_reset_vals("reset");
      rst_n = 1'b1;
      step();

      // Row, column/row-25 and row-0 fetches with an always-ready consumer.
      do_req(3, 1'b0, hs);
      do_req(25, 1'b0, hs);
      do_req(0, 1'b0, hs);
      wait_idle();

      // Backpressure: consumer stalls 5 cycles in HOLD.
      vr_mode  = 2;
      vr_force = 1'b0;
      step();
      do_req(7, 1'b0, hs);
      t = 0;
      while (!vec_valid && t < 100) begin step(); t++; end
      if (!vec_valid) fail_msg("bp_vec_valid");
      repeat (5) step();
      vr_force = 1'b1;
      t = 0;
      while (vec_valid && t < 20) begin step(); t++; end
      if (vec_valid) fail_msg("bp_release");
      vr_mode = 0;
      wait_idle();

      // Reset while element 7 is on the bus.
      do_req(5, 1'b0, hs);
      while (cyc < hs + 8) step();
      chk("mem_en_elem7", VW'(mem_en), VW'(1));
      rst_n = 1'b0;
      #1;
      chk_reset_vals("mid_reset");
      aq.delete();
      vq.delete();
      rq.delete();
      repeat (2) step();
      rst_n = 1'b1;
      step();
      do_req(1, 1'b0, hs);
      wait_idle();

      // Back-to-back with req_valid held high.
      for (int i = 0; i < 3; i++) begin
         do_req(int'($urandom_range(0, 2*VL-1)), 1'b1, hs);
         if (i > 0) chk("b2b_accept_cycle", VW'(hs), VW'(last_vhs + 1));
      end
      req_valid = 1'b0;
      wait_idle();

      // Random indices, random gaps, random consumer stalls.
      vr_mode = 1;
      for (int i = 0; i < 20; i++) begin
         do_req(int'($urandom_range(0, 2*VL-1)), 1'b0, hs);
         repeat ($urandom_range(0, 3)) step();
      end
      vr_mode = 0;
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
